// File: rtl/game_pkg.sv
// Shared constants, FSM state type and tile-wrap helper for the board-game referee.
package game_pkg;

  localparam int unsigned N_TILES = 24;
  localparam int unsigned POS_W   = 5;
  localparam int unsigned IMG_W   = 4;
  localparam int unsigned MAX_P   = 4;

  // Legal player-count range; anything else falls back to N_MIN.
  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCompare,
    StMoveHi,
    StMoveLo,
    StPass
  } state_e;

  // Explicit wrap so the loop never depends on POS_W overflow.
  function automatic logic [POS_W-1:0] next_tile(input logic [POS_W-1:0] p);
    return (p == POS_W'(N_TILES - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/occ_check.sv
// Flags whether a candidate tile is held by any other active player.
module occ_check
  import game_pkg::*;
(
  input  logic [POS_W-1:0]       target,
  input  logic [1:0]             cur,
  input  logic [2:0]             n_act,
  input  logic [MAX_P*POS_W-1:0] pos_bus,
  output logic                   occupied
);

  always_comb begin
    occupied = 1'b0;
    for (int i = 0; i < MAX_P; i++) begin
      if ((i < int'(n_act)) && (i != int'(cur)) &&
          (pos_bus[i*POS_W +: POS_W] == target)) begin
        occupied = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_judge.sv
// Referee FSM: matches a flipped card against the next free tile ahead of the current
// player, then either pulses that player's position counter or passes the turn.
module turn_judge
  import game_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             N,
  input  logic                   card_valid,
  input  logic [IMG_W-1:0]       card_img,
  input  logic [MAX_P*POS_W-1:0] pos_bus,
  output logic [POS_W-1:0]       tile_addr,
  input  logic [IMG_W-1:0]       tile_img,
  output logic [MAX_P-1:0]       p_da,
  output logic [1:0]             cur_player,
  output logic                   turn_over,
  output logic                   busy
);

  state_e           state_q;
  logic [IMG_W-1:0] card_q;
  logic [POS_W-1:0] target_q;
  logic [1:0]       hops_q;
  logic [2:0]       moves_q;
  logic [1:0]       cur_q;
  logic [2:0]       n_act_q;
  logic [MAX_P-1:0] p_da_q;
  logic             turn_over_q;
  logic             busy_q;

  logic             occupied;
  logic [POS_W-1:0] cur_pos;
  logic             hops_sat;
  logic [1:0]       cur_next;
  logic [MAX_P-1:0] cur_mask;

  occ_check u_occ_check (
    .target   (target_q),
    .cur      (cur_q),
    .n_act    (n_act_q),
    .pos_bus  (pos_bus),
    .occupied (occupied)
  );

  always_comb begin
    cur_pos = '0;
    for (int i = 0; i < MAX_P; i++) begin
      if (cur_q == 2'(i)) cur_pos = pos_bus[i*POS_W +: POS_W];
    end
  end

  assign hops_sat = ({1'b0, hops_q} == n_act_q - 3'd1);
  assign cur_next = ({1'b0, cur_q} == n_act_q - 3'd1) ? 2'd0 : cur_q + 2'd1;
  assign cur_mask = MAX_P'(1) << cur_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      card_q      <= '0;
      target_q    <= '0;
      hops_q      <= '0;
      moves_q     <= '0;
      cur_q       <= '0;
      p_da_q      <= '0;
      turn_over_q <= 1'b0;
      busy_q      <= 1'b0;
      n_act_q     <= (N >= 4'(N_MIN) && N <= 4'(N_MAX)) ? N[2:0] : 3'(N_MIN);
    end else begin
      p_da_q      <= '0;
      turn_over_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (card_valid) begin
            card_q   <= card_img;
            target_q <= next_tile(cur_pos);
            hops_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= StLookup;
          end
        end
        // target_q doubles as the ROM address, so the data lands in time for StCompare.
        StLookup: begin
          if (occupied && !hops_sat) begin
            target_q <= next_tile(target_q);
            hops_q   <= hops_q + 2'd1;
          end else begin
            state_q <= StCompare;
          end
        end
        StCompare: begin
          if (tile_img == card_q) begin
            moves_q <= {1'b0, hops_q} + 3'd1;
            p_da_q  <= cur_mask;
            state_q <= StMoveHi;
          end else begin
            turn_over_q <= 1'b1;
            state_q     <= StPass;
          end
        end
        StMoveHi: begin
          moves_q <= moves_q - 3'd1;
          state_q <= StMoveLo;
        end
        // Low gap lets the position counter settle before the next pulse or card.
        StMoveLo: begin
          if (moves_q != 3'd0) begin
            p_da_q  <= cur_mask;
            state_q <= StMoveHi;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StPass: begin
          cur_q   <= cur_next;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tile_addr  = target_q;
  assign p_da       = p_da_q;
  assign cur_player = cur_q;
  assign turn_over  = turn_over_q;
  assign busy       = busy_q;

endmodule
